// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer: wide adder/subtractor that streams a WIDTH-bit
// operation through one shared 16-bit carry-lookahead adder, one 16-bit
// chunk per cycle, LSB chunk first, with the carry held in a register
// between chunks. Valid/ready handshakes on request and result sides.

// 16-bit carry-lookahead adder: four 4-bit groups with group-level lookahead.
module cla_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] s_o,
  output logic        cout_o
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  pg_s;
  logic [3:0]  gc_s;

  // Bit/group generate-propagate terms, lookahead carries and sum bits.
  always_comb begin
    g_s = a_i & b_i;
    p_s = a_i ^ b_i;
    for (int k = 0; k < 4; k++) begin
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      pg_s[k] = &p_s[4*k +: 4];
    end
    gc_s[0] = cin_i;
    gc_s[1] = gg_s[0] | (pg_s[0] & cin_i);
    gc_s[2] = gg_s[1] | (pg_s[1] & gg_s[0]) | (pg_s[1] & pg_s[0] & cin_i);
    gc_s[3] = gg_s[2] | (pg_s[2] & gg_s[1]) | (pg_s[2] & pg_s[1] & gg_s[0])
            | (pg_s[2] & pg_s[1] & pg_s[0] & cin_i);
    cout_o  = gg_s[3] | (pg_s[3] & gg_s[2]) | (pg_s[3] & pg_s[2] & gg_s[1])
            | (pg_s[3] & pg_s[2] & pg_s[1] & gg_s[0])
            | (pg_s[3] & pg_s[2] & pg_s[1] & pg_s[0] & cin_i);
    for (int k = 0; k < 4; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
    s_o = p_s ^ c_s;
  end

endmodule

module cla_chunk_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int N    = WIDTH / 16;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;      // operand after optional inversion
  logic [WIDTH-1:0] acc_q;    // partial result built chunk by chunk
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept_s;
  logic             last_s;
  logic [15:0]      x_chunk_s;
  logic [15:0]      y_chunk_s;
  logic [15:0]      cla_sum_s;
  logic             cla_cout_s;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_s;

  assign accept_s = in_valid & in_ready;
  assign last_s   = (idx_q == LAST_IDX);

  // Select the current chunk of both latched operands.
  always_comb begin
    x_chunk_s = x_q[{idx_q, 4'b0000} +: 16];
    y_chunk_s = y_q[{idx_q, 4'b0000} +: 16];
  end

  cla_16 u_cla (
    .a_i    (x_chunk_s),
    .b_i    (y_chunk_s),
    .cin_i  (carry_q),
    .s_o    (cla_sum_s),
    .cout_o (cla_cout_s)
  );

  // Merge this cycle's chunk into the partial result and derive signed overflow.
  always_comb begin
    acc_d = acc_q;
    acc_d[{idx_q, 4'b0000} +: 16] = cla_sum_s;
    ovf_s = (x_q[WIDTH-1] == y_q[WIDTH-1]) & (acc_d[WIDTH-1] != x_q[WIDTH-1]);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept in IDLE, N chunk cycles in RUN, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register; reset blocks new requests.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = ~rst;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Datapath: latch operands on accept, step one chunk per RUN cycle, publish on last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            x_q     <= in_x;
            y_q     <= in_sub ? ~in_y : in_y;
            carry_q <= in_sub;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          carry_q <= cla_cout_s;
          idx_q   <= idx_q + ONE_IDX;
          if (last_s) begin
            sum_q  <= acc_d;
            cout_q <= cla_cout_s;
            ovf_q  <= ovf_s;
          end
        end
        default: begin
          idx_q <= idx_q;
        end
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Self-checking bench for cla_chunk_sequencer (WIDTH=64): directed corner
// cases, handshake back-pressure, mid-operation reset, then randomized
// operations against an arithmetic reference model.
module tb_cla_chunk_sequencer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_res    = 0;

  always #5 clk = ~clk;

  cla_chunk_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum} from plain arithmetic.
  function automatic logic [65:0] ref_op(input logic [63:0] x, input logic [63:0] y, input logic sub);
    logic [64:0] t;
    logic [63:0] s;
    logic        c;
    logic        v;
    if (!sub) begin
      t = {1'b0, x} + {1'b0, y};
      s = t[63:0];
      c = t[64];
      v = (x[63] == y[63]) && (s[63] != x[63]);
    end else begin
      s = x - y;
      c = (x >= y);
      v = (x[63] != y[63]) && (s[63] != x[63]);
    end
    return {v, c, s};
  endfunction

  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic sub,
                        input int pre_gap, input int hold, input bit rnd_ready,
                        output logic [63:0] o_sum, output logic o_cout, output logic o_ovf);
    logic [65:0] exp;
    int wcnt;
    int cyc;
    for (int i = 0; i < pre_gap; i++) begin
      in_valid = 1'b0;
      step();
    end
    in_x = x; in_y = y; in_sub = sub; in_valid = 1'b1;
    wcnt = 0;
    while (!in_ready && wcnt < 50) begin
      step();
      wcnt++;
    end
    check("in_ready_before_accept", in_ready, 1);
    step();
    n_acc++;
    exp = ref_op(x, y, sub);
    in_valid = 1'b0;
    in_x = {$urandom, $urandom};
    in_y = {$urandom, $urandom};
    in_sub = 1'($urandom_range(0, 1));
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check("busy_run", busy, 1);
      check("in_ready_run", in_ready, 0);
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      else           out_ready = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    check("out_valid_rise", out_valid, 1);
    check("latency", cyc, 4);
    if (out_valid) n_res++;
    check("sum", out_sum, exp[63:0]);
    check("cout", out_cout, exp[64]);
    check("ovf", out_ovf, exp[65]);
    o_sum = out_sum; o_cout = out_cout; o_ovf = out_ovf;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_x = {$urandom, $urandom};
      step();
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, exp[63:0]);
      check("hold_flags", {out_ovf, out_cout}, {exp[65], exp[64]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_after_take", busy, 0);
    check("sum_kept", out_sum, exp[63:0]);
  endtask

  initial begin
    logic [63:0] s;
    logic        c;
    logic        v;
    logic [63:0] rx;
    logic [63:0] ry;
    int          saw_valid;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_sub = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, 64'h0);
    check("rst_flags", {out_ovf, out_cout}, 2'b00);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed arithmetic corners
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0, 1'b0, s, c, v);
    check("t1_sum", s, 64'h0); check("t1_cout", c, 1); check("t1_ovf", v, 0);
    run_op(64'h5, 64'h7, 1'b1, 1, 1, 1'b1, s, c, v);
    check("t2_sum", s, 64'hFFFF_FFFF_FFFF_FFFE); check("t2_cout", c, 0); check("t2_ovf", v, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0, 1'b0, s, c, v);
    check("t3a_sum", s, 64'h8000_0000_0000_0000); check("t3a_cout", c, 0); check("t3a_ovf", v, 1);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 0, 0, 1'b0, s, c, v);
    check("t3b_sum", s, 64'h7FFF_FFFF_FFFF_FFFF); check("t3b_cout", c, 1); check("t3b_ovf", v, 1);

    // Back-pressure: 10 cycles in DONE with new requests, then next op accepted
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 0, 10, 1'b0, s, c, v);
    check("t4_sum", s, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h10, 64'h20, 1'b1, 0, 0, 1'b0, s, c, v);
    check("t4_next_sum", s, 64'hFFFF_FFFF_FFFF_FFF0);

    // Reset during the second RUN cycle aborts the op
    in_x = 64'hAAAA_AAAA_AAAA_AAAA; in_y = 64'h5555; in_sub = 1'b0; in_valid = 1'b1;
    check("t5_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("t5_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_sum", out_sum, 64'h0);
    check("t5_flags", {out_ovf, out_cout}, 2'b00);
    saw_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) saw_valid++;
      step();
    end
    check("t5_no_valid", saw_valid, 0);
    run_op(64'h1234, 64'h4321, 1'b0, 0, 0, 1'b0, s, c, v);
    check("t5_follow_sum", s, 64'h5555);

    // Randomized operations
    for (int n = 0; n < 1000; n++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rx = 64'hFFFF_FFFF_FFFF_FFFF;
        1: rx = 64'h8000_0000_0000_0000;
        2: rx = 64'h7FFF_FFFF_FFFF_FFFF;
        3: ry = rx;
        4: ry = {48'h0, ry[15:0]};
        default: rx = rx;
      endcase
      run_op(rx, ry, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
             1'b1, s, c, v);
    end
    check("result_count", n_res, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
